// File: rtl/mult_seq_unit.sv
// Iterative shift-add multiplier serving MULT/MFLO: one product bit per cycle into HI/LO.
// Optional MULT_SIGNED_EN selects signed (MULT) semantics; otherwise unsigned (MULTU).
module mult_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             store_values,
    input  logic             mult_enable,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] mflo_data,
    output logic [WIDTH-1:0] hi_data,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_start;
    logic               w_iter;
    logic               w_commit;
    logic               w_last;

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [2*WIDTH-1:0] w_acc_sum;
    logic [2*WIDTH-1:0] w_result;

    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    // The final iteration's partial product must be folded in before committing.
    assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef MULT_SIGNED_EN
    logic r_sign;

    assign w_rs_mag = rs_data[WIDTH-1] ? (-rs_data) : rs_data;
    assign w_rt_mag = rt_data[WIDTH-1] ? (-rt_data) : rt_data;
    assign w_result = r_sign ? (-w_acc_sum) : w_acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (w_start) begin
            r_sign <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
        end
    end
`else
    assign w_rs_mag = rs_data;
    assign w_rt_mag = rt_data;
    assign w_result = w_acc_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A new start always wins, including over the commit edge of an in-flight multiply.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_iter       = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (store_values) begin
                    w_start      = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (store_values) begin
                    w_start = 1'b1;
                end else begin
                    w_iter = 1'b1;
                    if (w_last) begin
                        w_commit     = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_start) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_rs_mag};
                r_mplier <= w_rt_mag;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (w_iter) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
            if (w_commit) begin
                r_hi <= w_result[2*WIDTH-1:WIDTH];
                r_lo <= w_result[WIDTH-1:0];
            end
        end
    end

    assign busy      = (r_state == CALC);
    assign stall     = mult_enable & busy;
    assign mflo_data = (mult_enable && !busy) ? r_lo : '0;
    assign hi_data   = r_hi;
    assign done      = r_done;

endmodule

// File: tb/tb_mult_seq_unit.sv
// Directed bench for mult_seq_unit: a product/countdown model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_mult_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         store_values = 1'b0;
    logic         mult_enable = 1'b0;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic [W-1:0] mflo_data;
    logic [W-1:0] hi_data;
    logic         busy;
    logic         stall;
    logic         done;

    int n_vec  = 0;
    int n_fail = 0;
    int done_seen = 0;

    mult_seq_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .store_values (store_values),
        .mult_enable  (mult_enable),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .mflo_data    (mflo_data),
        .hi_data      (hi_data),
        .busy         (busy),
        .stall        (stall),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
    endfunction

    // Model: a started product becomes visible W edges after the start edge.
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;
    logic [2*W-1:0] m_pend = '0;
    int             m_rem = 0;
    logic           m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (store_values) begin
                m_pend = model_prod(rs_data, rt_data);
                m_rem  = W;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic         e_busy;
        logic [W-1:0] e_mflo;
        e_busy = (m_rem > 0);
        e_mflo = (mult_enable && !e_busy) ? m_lo : '0;
        if (done === 1'b1) done_seen = done_seen + 1;
        chk("busy", 64'(busy), 64'(e_busy));
        chk("stall", 64'(stall), 64'(mult_enable & e_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("mflo_data", 64'(mflo_data), 64'(e_mflo));
        chk("hi_data", 64'(hi_data), 64'(m_hi));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b);
        store_values = 1'b1;
        rs_data = a;
        rt_data = b;
        cyc(1);
        store_values = 1'b0;
    endtask

    task automatic read_lo(output logic [W-1:0] lo, output logic st);
        mult_enable = 1'b1;
        @(negedge clk);
        lo = mflo_data;
        st = stall;
        cyc(1);
        mult_enable = 1'b0;
    endtask

    logic [W-1:0] lo;
    logic         st;
    int           base;
    int           nstall;
    logic [W-1:0] va [6] = '{32'd0, 32'h8000_0000, 32'h1234_5678, 32'd65535, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    logic [W-1:0] vb [6] = '{32'd5, 32'd2, 32'h9ABC_DEF0, 32'd65537, 32'h7FFF_FFFF, 32'd3};

    initial begin
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", 64'(hi_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        // 6 x 7
        base = done_seen;
        cyc(1);
        mult(32'd6, 32'd7);
        cyc(W);
        read_lo(lo, st);
        chk("6x7_lo", 64'(lo), 64'd42);
        chk("6x7_stall", 64'(st), 64'd0);
        chk("6x7_hi", 64'(hi_data), 64'd0);
        chk("6x7_done_pulses", 64'(done_seen - base), 64'd1);

        // all-ones squared and -3 x 5
        mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc(W);
        read_lo(lo, st);
`ifdef MULT_SIGNED_EN
        chk("m1xm1_lo", 64'(lo), 64'h1);
        chk("m1xm1_hi", 64'(hi_data), 64'h0);
        mult(32'hFFFF_FFFD, 32'd5);
        cyc(W);
        read_lo(lo, st);
        chk("m3x5_lo", 64'(lo), 64'hFFFF_FFF1);
        chk("m3x5_hi", 64'(hi_data), 64'hFFFF_FFFF);
`else
        chk("ffxff_lo", 64'(lo), 64'h1);
        chk("ffxff_hi", 64'(hi_data), 64'hFFFF_FFFE);
`endif

        for (int i = 0; i < 6; i++) begin
            mult(va[i], vb[i]);
            cyc(W);
            read_lo(lo, st);
        end

        // MFLO from the 3rd busy cycle stalls for W-2 cycles
        mult(32'd1000, 32'd1000);
        cyc(2);
        mult_enable = 1'b1;
        nstall = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (!stall) break;
            nstall = nstall + 1;
        end
        chk("stall_cycles", 64'(nstall), 64'(W - 2));
        chk("stall_mflo", 64'(mflo_data), 64'd1000000);
        cyc(1);
        mult_enable = 1'b0;

        // restart at 10th busy cycle: single commit, W cycles after second start
        base = done_seen;
        mult(32'd2, 32'd3);
        cyc(9);
        mult(32'd4, 32'd5);
        cyc(W - 1);
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_no_early_done", 64'(done_seen - base), 64'd0);
        cyc(1);
        read_lo(lo, st);
        chk("restart_lo", 64'(lo), 64'd20);
        chk("restart_done_pulses", 64'(done_seen - base), 64'd1);

        // MULT and MFLO together from IDLE
        store_values = 1'b1; rs_data = 32'd11; rt_data = 32'd13; mult_enable = 1'b1;
        @(negedge clk);
        chk("same_cycle_stall", 64'(stall), 64'd0);
        chk("same_cycle_mflo", 64'(mflo_data), 64'd20);
        cyc(1);
        store_values = 1'b0;
        @(negedge clk);
        chk("calc_mflo_zero", 64'(mflo_data), 64'd0);
        mult_enable = 1'b0;
        cyc(W);
        read_lo(lo, st);
        chk("11x13_lo", 64'(lo), 64'd143);

        // reset mid-calculation
        mult(32'd123456789, 32'd987654321);
        cyc(W);
        mult(32'd123, 32'd456);
        cyc(5);
        mult_enable = 1'b1;
        rst = 1'b1;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mflo", 64'(mflo_data), 64'd0);
        chk("rst_hi", 64'(hi_data), 64'd0);
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_lo_zero", 64'(mflo_data), 64'd0);
        cyc(1);
        mult_enable = 1'b0;
        mult(32'd9, 32'd9);
        cyc(W);
        read_lo(lo, st);
        chk("9x9_lo", 64'(lo), 64'd81);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq_unit.md
# mult_seq_unit

Iterative shift-add multiplier datapath that executes the MULT instruction and serves MFLO reads in the single-cycle MIPS core. It consumes the `store_values` and `mult_enable` strobes decoded from opcode/funct by the multiplication control logic, latches `rs`/`rt` operands, computes a 2×WIDTH product over WIDTH cycles into internal HI/LO registers, and returns LO on MFLO. It stalls the pipeline when MFLO is issued before the product is ready.

## Interface
- `WIDTH`, default 32: operand width; the product is 2×WIDTH bits split into HI and LO.
- `clk`  input  1  core clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `store_values`  input  1  MULT decoded; start a multiply with `rs_data`/`rt_data`.
- `mult_enable`  input  1  MFLO decoded; request the LO value.
- `rs_data`  input  WIDTH  multiplicand, sampled with `store_values`.
- `rt_data`  input  WIDTH  multiplier, sampled with `store_values`.
- `mflo_data`  output  WIDTH  LO register when `mult_enable`=1 and `busy`=0, else 0.
- `hi_data`  output  WIDTH  HI register, always visible.
- `busy`  output  1  multiply in progress.
- `stall`  output  1  `mult_enable & busy`, combinational; freezes the PC and IF/ID.
- `done`  output  1  one-cycle pulse on the cycle after the product is committed.

## Operation
- States: IDLE, CALC.
- IDLE + `store_values`=1 at an edge:
  - Latch the operand magnitudes.
  - Record `sign = rs[WIDTH-1] ^ rt[WIDTH-1]`. The sign is signed mode only; it is 0 otherwise.
  - Clear the 2×WIDTH accumulator and the iteration counter.
  - Move to CALC.
- CALC, each edge:
  - If multiplier bit 0 is 1, add the multiplicand (2×WIDTH wide, zero-extended) to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1.
  - Increment the counter.
- Last iteration (counter = WIDTH-1):
  - Commit `{HI,LO}` = accumulator result, two's-complement negated over 2×WIDTH bits if `sign`=1.
  - Return to IDLE. `done` is high the following cycle.
- Arithmetic is modulo 2^(2×WIDTH). No overflow flag.
- HI/LO keep their value until the next commit or reset. A new MULT does not clear them until it commits.
- `store_values` during CALC: abort the current multiply, relatch the new operands, restart at counter 0. HI/LO are untouched.
- `store_values` and `mult_enable` in the same cycle (not legal in one instruction, but must be handled): the start takes effect; `stall`=0 if the unit was IDLE, and `mflo_data` returns the old LO.
- `mult_enable` during CALC: `stall`=1 and `mflo_data`=0 until the commit edge. The next cycle returns the new LO with `stall`=0.
- Reset, including mid-CALC:
  - State → IDLE; counter and accumulator → 0.
  - HI = LO = 0; `busy`, `stall`, `done`, `mflo_data` = 0.
  - `hi_data` = 0.

## Timing
- Edge E0 samples `store_values`. Iterations run on E1..E_WIDTH. HI/LO update on E_WIDTH.
- `busy` is high from after E0 until after E_WIDTH: exactly WIDTH cycles.
- `done` is high for one cycle after E_WIDTH.
- Minimum MULT→MFLO distance without a stall: WIDTH+1 cycles. Earlier MFLOs stall for the remainder.
- `stall` and `mflo_data` are combinational from `mult_enable` and registered state, with no extra cycle.

## Configuration
- `MULT_SIGNED_EN` defined: MULT semantics. Operands are two's complement; magnitudes are taken at latch, and the result is negated when signs differ.
- Not defined: MULTU semantics. Operands are unsigned, `sign` is forced to 0, and the negation logic is removed.
- Latency is identical in both builds.

## Test plan
- Reset, then MULT 6×7, waiting WIDTH+1 cycles → LO=42, HI=0. `done` pulses once. MFLO → `mflo_data`=42, `stall`=0.
- With `MULT_SIGNED_EN`: −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. 0xFFFFFFFF×0xFFFFFFFF → HI=0, LO=1.
- Without the macro: 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- MULT 1000×1000, then MFLO held from the 3rd cycle → `stall`=1 for exactly WIDTH−2 cycles, then `mflo_data`=1000000 with `stall`=0.
- MULT 2×3, then MULT 4×5 at the 10th busy cycle → a single commit with LO=20, WIDTH cycles after the second start. LO=6 is never visible.
- Assert `rst` mid-CALC → all outputs 0 immediately, HI/LO=0. A subsequent MULT 9×9 gives LO=81.
